commit_trace_serializer: RTL
============================

// Module: commit_trace_serializer
// PURPOSE
//  Consumes the dual-issue commit debug ports of mycpu_top (master + slave lanes) and
//  serializes them into a single-lane, in-order register-writeback trace stream for the
//  golden-trace comparator / trace dumper. Buffers bursts of two commits per cycle in a
//  2-write/1-read FIFO. Never back-pressures the CPU; drops and flags on overflow.
// PARAMETERS
//  DEPTH      16   FIFO entries; power of two, >= 4
//  DCNT_W     16   width of saturating drop counter
// PORTS
//  aclk                      in   1   core clock
//  aresetn                   in   1   asynchronous active-low reset
//  debug_pc_master           in   32  PC of master-lane commit
//  debug_wb_rf_wen_master    in   4   byte write enables, master lane
//  debug_wb_rf_wnum_master   in   5   destination register, master lane
//  debug_wb_rf_wdata_master  in   32  write data, master lane
//  debug_pc_slave            in   32  PC of slave-lane commit
//  debug_wb_rf_wen_slave     in   4   byte write enables, slave lane
//  debug_wb_rf_wnum_slave    in   5   destination register, slave lane
//  debug_wb_rf_wdata_slave   in   32  write data, slave lane
//  trace_valid               out  1   head entry valid
//  trace_ready               in   1   consumer accepts head entry
//  trace_pc                  out  32  head PC
//  trace_wen                 out  4   head byte enables
//  trace_wnum                out  5   head register number
//  trace_wdata               out  32  head write data
//  trace_overflow            out  1   sticky: at least one commit dropped
//  trace_drop_cnt            out  DCNT_W  saturating count of dropped commits
// BEHAVIOUR
//  - Lane commit qualifies when wen != 4'b0000 AND wnum != 5'd0; else ignored.
//  - Order: same-cycle master entry precedes slave entry. Pushes per cycle: 0, 1 or 2.
//  - Pop when trace_valid && trace_ready (one per cycle). trace_valid = (count != 0).
//  - Latency: commit sampled at edge N appears on trace_* after edge N (cycle N+1) if empty.
//  - trace_* driven from head entry; stable while trace_valid && !trace_ready.
//  - Space check includes same-cycle pop: accept if count - pop + push <= DEPTH.
//  - Overflow: if only one slot free and two qualify, master stored, slave dropped;
//    zero free -> both dropped. Each drop: trace_overflow <= 1, trace_drop_cnt += n,
//    saturating at all-ones (no wrap).
//  - Pointers: log2(DEPTH)-bit wrap naturally; count is log2(DEPTH)+1 bits.
//  - Write of slave uses wptr+1 (mod DEPTH) when master also written, else wptr.
//  - Reset (async, aresetn=0): wptr/rptr/count=0, trace_valid=0, trace_pc/wen/wnum/wdata=0
//    (head reads as zero when empty), trace_overflow=0, trace_drop_cnt=0. Reset mid-stream
//    discards all buffered entries; first post-reset commit is entry 0.
//  - No FSM beyond FIFO occupancy: states EMPTY / PARTIAL / FULL derived from count.
// CONFIGURATION
//  - Macro TRACE_TIMESTAMP_EN defined: 32-bit free-running cycle counter (reset 0, wraps),
//    extra output trace_cycle [31:0] = counter value at push; both lanes of one cycle carry
//    the same stamp; stored per entry. Undefined: no counter, no trace_cycle port.
// STRUCTURE
//  - Package trace_pkg: typedef commit_entry_t {pc[31:0], wen[3:0], wnum[4:0], wdata[31:0]
//    [, cycle[31:0] under TRACE_TIMESTAMP_EN]}; constants TRACE_PC_W=32, TRACE_WNUM_W=5.
//  - Sub-module trace_fifo_2w1r (DEPTH, entry type): two write ports, one read port,
//    count/space outputs. Top handles qualification, ordering, drop accounting.
// TESTING
//  1 Master-only commit pc=0xBFC00000 wnum=8 wdata=0x1234, ready=1 -> one beat next cycle, same fields.
//  2 Both lanes pc=0x100/0x104 same cycle, ready=1 -> beats 0x100 then 0x104 on consecutive cycles.
//  3 wnum=0 with wen=4'hF, and wnum=3 with wen=0 -> no trace beat, count stays 0.
//  4 ready=0, DEPTH=16, 8 dual commits fill FIFO; 9th dual -> both dropped, overflow=1,
//    drop_cnt=2; with 15 filled + dual -> master kept, drop_cnt=1.
//  5 Full FIFO, ready=1, single commit same cycle -> accepted (pop-aware), no drop.
//  6 Assert aresetn=0 with 5 entries buffered -> trace_valid=0, all outputs 0 immediately;
//    after release, new commit pc=0x200 is first beat.

Source files
------------

// File: rtl/commit_trace_serializer_pkg.sv
// -----------------------------------------------------------------------------
// trace_pkg
// Shared types and constants for the commit trace serializer.
//   commit_entry_t : one register-writeback trace record (pc, wen, wnum, wdata
//                    and, with TRACE_TIMESTAMP_EN defined, the push cycle stamp)
//   OCC_*          : FIFO occupancy states, derived from the entry count
//   lane_qualifies : a lane commit is traced only if it really writes a register
// Optional feature macro: TRACE_TIMESTAMP_EN (adds the cycle field).
// -----------------------------------------------------------------------------
package trace_pkg;

  localparam int TRACE_PC_W   = 32;
  localparam int TRACE_WNUM_W = 5;

  // Occupancy "states"; there is no other sequencing in this block.
  localparam logic [1:0] OCC_EMPTY   = 2'd0;
  localparam logic [1:0] OCC_PARTIAL = 2'd1;
  localparam logic [1:0] OCC_FULL    = 2'd2;

  typedef struct packed {
    logic [TRACE_PC_W-1:0]   pc;
    logic [3:0]              wen;
    logic [TRACE_WNUM_W-1:0] wnum;
    logic [31:0]             wdata;
`ifdef TRACE_TIMESTAMP_EN
    logic [31:0]             cycle;
`endif
  } commit_entry_t;

  // Writes to r0 or with no byte enables are architectural no-ops.
  function automatic logic lane_qualifies(input logic [3:0] wen,
                                          input logic [TRACE_WNUM_W-1:0] wnum);
    return (wen != 4'b0000) && (wnum != '0);
  endfunction

  function automatic logic [1:0] occ_state(input int cnt, input int depth);
    if (cnt == 0)          return OCC_EMPTY;
    else if (cnt >= depth) return OCC_FULL;
    else                   return OCC_PARTIAL;
  endfunction

endpackage

// File: rtl/commit_trace_serializer_if.sv
// -----------------------------------------------------------------------------
// commit_trace_serializer_if
// Bundles the dual-lane commit debug inputs and the single-lane trace output.
//   modport master : CPU / trace consumer side (drives debug_*, trace_ready)
//   modport slave  : serializer side (drives trace_* except trace_ready)
// Parameter DCNT_W sizes trace_drop_cnt.
// Optional feature macro: TRACE_TIMESTAMP_EN (adds trace_cycle [31:0]).
// -----------------------------------------------------------------------------
interface commit_trace_serializer_if #(
  parameter int DCNT_W = 16
);
  logic [31:0]       debug_pc_master;
  logic [3:0]        debug_wb_rf_wen_master;
  logic [4:0]        debug_wb_rf_wnum_master;
  logic [31:0]       debug_wb_rf_wdata_master;
  logic [31:0]       debug_pc_slave;
  logic [3:0]        debug_wb_rf_wen_slave;
  logic [4:0]        debug_wb_rf_wnum_slave;
  logic [31:0]       debug_wb_rf_wdata_slave;
  logic              trace_valid;
  logic              trace_ready;
  logic [31:0]       trace_pc;
  logic [3:0]        trace_wen;
  logic [4:0]        trace_wnum;
  logic [31:0]       trace_wdata;
  logic              trace_overflow;
  logic [DCNT_W-1:0] trace_drop_cnt;
`ifdef TRACE_TIMESTAMP_EN
  logic [31:0]       trace_cycle;
`endif

  modport master (
    output debug_pc_master, debug_wb_rf_wen_master, debug_wb_rf_wnum_master,
           debug_wb_rf_wdata_master, debug_pc_slave, debug_wb_rf_wen_slave,
           debug_wb_rf_wnum_slave, debug_wb_rf_wdata_slave, trace_ready,
    input  trace_valid, trace_pc, trace_wen, trace_wnum, trace_wdata,
`ifdef TRACE_TIMESTAMP_EN
           trace_cycle,
`endif
           trace_overflow, trace_drop_cnt
  );

  modport slave (
    input  debug_pc_master, debug_wb_rf_wen_master, debug_wb_rf_wnum_master,
           debug_wb_rf_wdata_master, debug_pc_slave, debug_wb_rf_wen_slave,
           debug_wb_rf_wnum_slave, debug_wb_rf_wdata_slave, trace_ready,
    output trace_valid, trace_pc, trace_wen, trace_wnum, trace_wdata,
`ifdef TRACE_TIMESTAMP_EN
           trace_cycle,
`endif
           trace_overflow, trace_drop_cnt
  );

endinterface

// File: rtl/commit_trace_serializer_fifo.sv
// -----------------------------------------------------------------------------
// trace_fifo_2w1r
// Two-write / one-read FIFO of trace entries.
//   clk_i, rst_ni   : clock, asynchronous active-low reset (pointers/count only)
//   we0_i, wd0_i    : write port 0 (master lane), written at wptr
//   we1_i, wd1_i    : write port 1 (slave lane), written at wptr+1 when port 0
//                     also writes this cycle, else at wptr
//   re_i            : pop the head entry (ignored when empty)
//   rd_o            : head entry, all zeros while empty
//   count_o/space_o : occupancy and free slots
// The caller guarantees writes never exceed the free space (after pop).
// -----------------------------------------------------------------------------
module trace_fifo_2w1r
  import trace_pkg::*;
#(
  parameter int  DEPTH   = 16,
  parameter type entry_t = commit_entry_t
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       we0_i,
  input  entry_t                     wd0_i,
  input  logic                       we1_i,
  input  entry_t                     wd1_i,
  input  logic                       re_i,
  output entry_t                     rd_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic [$clog2(DEPTH):0]     space_o
);
  localparam int AW = $clog2(DEPTH);

  entry_t            mem_q [DEPTH];
  logic [AW-1:0]     wptr_q, wptr_d;
  logic [AW-1:0]     rptr_q, rptr_d;
  logic [AW:0]       count_q, count_d;
  logic [AW-1:0]     waddr1;
  logic              pop;

  always_comb begin
    pop     = re_i && (count_q != '0);
    waddr1  = we0_i ? wptr_q + AW'(1) : wptr_q;
    wptr_d  = wptr_q + AW'(we0_i) + AW'(we1_i);
    rptr_d  = rptr_q + AW'(pop);
    count_d = count_q + (AW+1)'(we0_i) + (AW+1)'(we1_i) - (AW+1)'(pop);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage holds data only; validity comes from count, so no reset needed.
  always_ff @(posedge clk_i) begin
    if (we0_i) mem_q[wptr_q] <= wd0_i;
    if (we1_i) mem_q[waddr1] <= wd1_i;
  end

  // Gating on count makes the head read as zero when empty and right after reset.
  assign rd_o    = (count_q != '0) ? mem_q[rptr_q] : '0;
  assign count_o = count_q;
  assign space_o = (AW+1)'(DEPTH) - count_q;

endmodule

// File: rtl/commit_trace_serializer.sv
// -----------------------------------------------------------------------------
// commit_trace_serializer
// Serializes the dual-issue commit debug ports (master + slave lanes) into an
// in-order single-lane register-writeback trace stream. Never stalls the CPU:
// commits that do not fit are dropped and counted.
//   aclk, aresetn : core clock, asynchronous active-low reset
//   bus (slave)   : debug_* commit inputs, trace_* valid/ready output stream,
//                   trace_overflow (sticky) and trace_drop_cnt (saturating)
// Parameters: DEPTH (FIFO entries, power of two >= 4), DCNT_W (drop counter).
// Optional feature macro: TRACE_TIMESTAMP_EN -- adds a free-running 32-bit cycle
// counter; every pushed entry carries the counter value, shown on trace_cycle.
// -----------------------------------------------------------------------------
module commit_trace_serializer
  import trace_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int DCNT_W = 16
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  commit_trace_serializer_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);

  commit_entry_t     ent_m, ent_s, head;
  logic              mq, sq;
  logic              we_m, we_s;
  logic              pop;
  logic [1:0]        occ;
  logic [AW:0]       fifo_count, fifo_space;
  logic [AW+1:0]     free;
  logic [1:0]        ndrop;
  logic              overflow_q, overflow_d;
  logic [DCNT_W-1:0] drop_cnt_q, drop_cnt_d;
`ifdef TRACE_TIMESTAMP_EN
  logic [31:0]       cycle_q;
`endif

  function automatic logic [DCNT_W-1:0] sat_add(input logic [DCNT_W-1:0] a,
                                                input logic [1:0] n);
    logic [DCNT_W:0] s;
    s = {1'b0, a} + {{(DCNT_W-1){1'b0}}, n};
    return s[DCNT_W] ? '1 : s[DCNT_W-1:0];
  endfunction

  always_comb begin
    ent_m       = '0;
    ent_m.pc    = bus.debug_pc_master;
    ent_m.wen   = bus.debug_wb_rf_wen_master;
    ent_m.wnum  = bus.debug_wb_rf_wnum_master;
    ent_m.wdata = bus.debug_wb_rf_wdata_master;
    ent_s       = '0;
    ent_s.pc    = bus.debug_pc_slave;
    ent_s.wen   = bus.debug_wb_rf_wen_slave;
    ent_s.wnum  = bus.debug_wb_rf_wnum_slave;
    ent_s.wdata = bus.debug_wb_rf_wdata_slave;
`ifdef TRACE_TIMESTAMP_EN
    ent_m.cycle = cycle_q;
    ent_s.cycle = cycle_q;
`endif
  end

  assign occ = occ_state(int'(fifo_count), DEPTH);
  assign pop = (occ != OCC_EMPTY) && bus.trace_ready;

  // Free slots counting the slot released by this cycle's pop; the master lane
  // claims the first slot so it wins when only one is left.
  always_comb begin
    mq    = lane_qualifies(bus.debug_wb_rf_wen_master, bus.debug_wb_rf_wnum_master);
    sq    = lane_qualifies(bus.debug_wb_rf_wen_slave, bus.debug_wb_rf_wnum_slave);
    free  = {1'b0, fifo_space} + (AW+2)'(pop);
    we_m  = mq && (free != '0);
    we_s  = sq && (mq ? (free >= (AW+2)'(2)) : (free != '0));
    ndrop = {1'b0, mq && !we_m} + {1'b0, sq && !we_s};
    overflow_d = overflow_q || (ndrop != 2'd0);
    drop_cnt_d = sat_add(drop_cnt_q, ndrop);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

`ifdef TRACE_TIMESTAMP_EN
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) cycle_q <= '0;
    else          cycle_q <= cycle_q + 32'd1;
  end
`endif

  trace_fifo_2w1r #(
    .DEPTH   (DEPTH),
    .entry_t (commit_entry_t)
  ) u_fifo (
    .clk_i   (aclk),
    .rst_ni  (aresetn),
    .we0_i   (we_m),
    .wd0_i   (ent_m),
    .we1_i   (we_s),
    .wd1_i   (ent_s),
    .re_i    (pop),
    .rd_o    (head),
    .count_o (fifo_count),
    .space_o (fifo_space)
  );

  assign bus.trace_valid    = (occ != OCC_EMPTY);
  assign bus.trace_pc       = head.pc;
  assign bus.trace_wen      = head.wen;
  assign bus.trace_wnum     = head.wnum;
  assign bus.trace_wdata    = head.wdata;
  assign bus.trace_overflow = overflow_q;
  assign bus.trace_drop_cnt = drop_cnt_q;
`ifdef TRACE_TIMESTAMP_EN
  assign bus.trace_cycle    = head.cycle;
`endif

endmodule
